// File: rtl/reg_scoreboard_pkg.sv
// ============================================================================
// Module      : reg_scoreboard_pkg
// Description : Shared definitions for the decode-stage register scoreboard.
//               These cover the XZR index, the register-index width, the
//               default in-flight capacity and the per-register state
//               encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_scoreboard_pkg;

    localparam int         SB_IDX_W            = 5;
    localparam logic [4:0] SB_XZR              = 5'd31;
    localparam int         SB_DEF_MAX_INFLIGHT = 4;

    // Per-register controller state; a busy_vec bit equals (state == REG_PENDING).
    typedef enum logic {
        REG_IDLE    = 1'b0,
        REG_PENDING = 1'b1
    } sb_reg_state_e;

    // XZR is the zero register: it is never tracked as a source or destination.
    function automatic logic sb_is_real(input logic [SB_IDX_W-1:0] idx);
        return (idx != SB_XZR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sb_hazard_check.sv
// ============================================================================
// Module      : sb_hazard_check
// Description : Combinational RAW/WAW hazard detection against the pending
//               write vector.
//   busy_vec          in   pending-write bit per register
//   dec_use_rn/dec_rn in   first source
//   dec_use_r2/dec_r2 in   second source
//   dec_reg_write/rd  in   destination
//   wb_valid/wb_rd    in   same-cycle writeback (SB_WB_BYPASS_EN only)
//   hazard            out  instruction must wait
// Config      : SB_WB_BYPASS_EN masks a same-cycle writeback out of busy_vec.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sb_hazard_check
    import reg_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic [NUM_REGS-1:0] busy_vec,
    input  logic                dec_use_rn,
    input  logic [4:0]          dec_rn,
    input  logic                dec_use_r2,
    input  logic [4:0]          dec_r2,
    input  logic                dec_reg_write,
    input  logic [4:0]          dec_rd,
`ifdef SB_WB_BYPASS_EN
    input  logic                wb_valid,
    input  logic [4:0]          wb_rd,
`endif
    output logic                hazard
);

    logic [NUM_REGS-1:0] w_busy_eff;

`ifdef SB_WB_BYPASS_EN
    // The register file writes before it reads within a cycle, so a register
    // completing this cycle can already be consumed (or rewritten).
    logic [NUM_REGS-1:0] w_wb_mask;
    assign w_wb_mask  = (wb_valid && sb_is_real(wb_rd))
                      ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << wb_rd) : '0;
    assign w_busy_eff = busy_vec & ~w_wb_mask;
`else
    assign w_busy_eff = busy_vec;
`endif

    assign hazard = (dec_use_rn    && sb_is_real(dec_rn) && w_busy_eff[dec_rn])
                  | (dec_use_r2    && sb_is_real(dec_r2) && w_busy_eff[dec_r2])
                  | (dec_reg_write && sb_is_real(dec_rd) && w_busy_eff[dec_rd]);

endmodule

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// ============================================================================
// Module      : reg_scoreboard
// Description : Decode-stage issue controller. Tracks the destinations of
//               in-flight writes and holds a decoded instruction while it has
//               a RAW/WAW hazard or while in-flight capacity is exhausted.
//   clk, rst_n        in   clock, synchronous active-low reset
//   dec_*             in   decoded instruction fields; dec_ready out
//   wb_valid, wb_rd   in   writeback completion
//   issue_fire        out  registered issue strobe (1-cycle latency)
//   busy_vec          out  pending-write bit per register
//   inflight_cnt      out  outstanding writes
//   stall_cnt         out  saturating count of stalled decode cycles
//   wb_err            out  sticky: writeback to a non-busy register
// Config      : define SB_WB_BYPASS_EN to let a same-cycle writeback clear
//               hazards and free capacity immediately.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int MAX_INFLIGHT = SB_DEF_MAX_INFLIGHT,
    parameter int STALL_W      = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                dec_valid,
    output logic                                dec_ready,
    input  logic [4:0]                          dec_rn,
    input  logic [4:0]                          dec_r2,
    input  logic                                dec_use_rn,
    input  logic                                dec_use_r2,
    input  logic                                dec_reg_write,
    input  logic [4:0]                          dec_rd,
    input  logic                                wb_valid,
    input  logic [4:0]                          wb_rd,
    output logic                                issue_fire,
    output logic [NUM_REGS-1:0]                 busy_vec,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]   inflight_cnt,
    output logic [STALL_W-1:0]                  stall_cnt,
    output logic                                wb_err
);

    localparam int               CNT_W   = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CNT_W-1:0] c_MAX   = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] c_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [STALL_W-1:0] c_SONE = {{(STALL_W-1){1'b0}}, 1'b1};
    localparam logic [NUM_REGS-1:0] c_BIT0 = {{(NUM_REGS-1){1'b0}}, 1'b1};

    logic [NUM_REGS-1:0] r_busy;
    logic [CNT_W-1:0]    r_cnt;
    logic [STALL_W-1:0]  r_stall;
    logic                r_issue_fire;
    logic                r_wb_err;

    logic                w_hazard;
    logic                w_full;
    logic                w_ready;
    logic                w_fire;
    logic                w_wr_real;
    logic                w_wb_real;
    logic                w_wb_hit;
    logic                w_wb_bad;
    logic                w_set;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;

    sb_hazard_check #(
        .NUM_REGS      (NUM_REGS)
    ) u_hazard (
        .busy_vec      (r_busy),
        .dec_use_rn    (dec_use_rn),
        .dec_rn        (dec_rn),
        .dec_use_r2    (dec_use_r2),
        .dec_r2        (dec_r2),
        .dec_reg_write (dec_reg_write),
        .dec_rd        (dec_rd),
`ifdef SB_WB_BYPASS_EN
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
`endif
        .hazard        (w_hazard)
    );

    assign w_wr_real = dec_reg_write && sb_is_real(dec_rd);
    assign w_wb_real = wb_valid && sb_is_real(wb_rd);
    assign w_wb_hit  = w_wb_real &&  r_busy[wb_rd];
    assign w_wb_bad  = w_wb_real && !r_busy[wb_rd];

`ifdef SB_WB_BYPASS_EN
    // A slot released by this cycle's writeback may be reused immediately.
    assign w_full = w_wr_real && (r_cnt == c_MAX) && !w_wb_hit;
`else
    assign w_full = w_wr_real && (r_cnt == c_MAX);
`endif

    // Ready is independent of dec_valid so decode can look ahead.
    assign w_ready = !w_hazard && !w_full;
    assign w_fire  = dec_valid && w_ready;
    assign w_set   = w_fire && w_wr_real;

    assign w_set_mask = w_set    ? (c_BIT0 << dec_rd) : '0;
    assign w_clr_mask = w_wb_hit ? (c_BIT0 << wb_rd)  : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy       <= '0;
            r_cnt        <= '0;
            r_stall      <= '0;
            r_issue_fire <= 1'b0;
            r_wb_err     <= 1'b0;
        end else begin
            // Set after clear: a bypassed rewrite of wb_rd keeps it pending.
            r_busy       <= (r_busy & ~w_clr_mask) | w_set_mask;
            r_issue_fire <= w_fire;

            // Simultaneous issue and retire leave the count unchanged.
            if (w_set && !w_wb_hit && (r_cnt != c_MAX)) begin
                r_cnt <= r_cnt + c_ONE;
            end else if (!w_set && w_wb_hit && (r_cnt != '0)) begin
                r_cnt <= r_cnt - c_ONE;
            end

            if (dec_valid && !w_ready && (r_stall != '1)) begin
                r_stall <= r_stall + c_SONE;
            end

            if (w_wb_bad) begin
                r_wb_err <= 1'b1;
            end
        end
    end

    assign dec_ready    = w_ready;
    assign issue_fire   = r_issue_fire;
    assign busy_vec     = r_busy;
    assign inflight_cnt = r_cnt;
    assign stall_cnt    = r_stall;
    assign wb_err       = r_wb_err;

endmodule

`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
// ============================================================================
// Module      : tb_reg_scoreboard
// Description : Directed self-checking bench for reg_scoreboard. Expectations
//               follow SB_WB_BYPASS_EN when it is defined for the build.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dec_valid;
    logic        dec_ready;
    logic [4:0]  dec_rn;
    logic [4:0]  dec_r2;
    logic        dec_use_rn;
    logic        dec_use_r2;
    logic        dec_reg_write;
    logic [4:0]  dec_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        issue_fire;
    logic [31:0] busy_vec;
    logic [2:0]  inflight_cnt;
    logic [15:0] stall_cnt;
    logic        wb_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_scoreboard #(
        .NUM_REGS      (32),
        .MAX_INFLIGHT  (4),
        .STALL_W       (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .dec_valid     (dec_valid),
        .dec_ready     (dec_ready),
        .dec_rn        (dec_rn),
        .dec_r2        (dec_r2),
        .dec_use_rn    (dec_use_rn),
        .dec_use_r2    (dec_use_r2),
        .dec_reg_write (dec_reg_write),
        .dec_rd        (dec_rd),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .issue_fire    (issue_fire),
        .busy_vec      (busy_vec),
        .inflight_cnt  (inflight_cnt),
        .stall_cnt     (stall_cnt),
        .wb_err        (wb_err)
    );

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        dec_valid = 0; dec_rn = 0; dec_r2 = 0; dec_use_rn = 0; dec_use_r2 = 0;
        dec_reg_write = 0; dec_rd = 0; wb_valid = 0; wb_rd = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL reset_busy got %h exp %h", busy_vec, 32'h0); end
        checks++; if (inflight_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", inflight_cnt); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d exp 0", stall_cnt); end
        checks++; if (issue_fire !== 1'b0) begin errors++; $display("FAIL reset_fire got %b exp 0", issue_fire); end
        checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL reset_wberr got %b exp 0", wb_err); end
    endtask

    task automatic test_raw();
        // ADD X1
        clear_inputs();
        dec_valid = 1; dec_reg_write = 1; dec_rd = 5'd1;
        #1;
        checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL raw_first_ready got %b exp 1", dec_ready); end
        tick();
        checks++; if (busy_vec !== 32'h2) begin errors++; $display("FAIL raw_busy got %h exp %h", busy_vec, 32'h2); end
        checks++; if (issue_fire !== 1'b1) begin errors++; $display("FAIL raw_fire1 got %b exp 1", issue_fire); end
        // Reader of X1
        dec_reg_write = 0; dec_rd = 0; dec_use_rn = 1; dec_rn = 5'd1;
        #1;
        checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL raw_stall_ready got %b exp 0", dec_ready); end
        tick(); tick();
        checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL raw_stall_cnt got %0d exp 2", stall_cnt); end
        checks++; if (issue_fire !== 1'b0) begin errors++; $display("FAIL raw_fire0 got %b exp 0", issue_fire); end
        wb_valid = 1; wb_rd = 5'd1;
        #1;
`ifdef SB_WB_BYPASS_EN
        checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL raw_wb_ready got %b exp 1", dec_ready); end
        tick();
        wb_valid = 0; dec_valid = 0;
        checks++; if (issue_fire !== 1'b1) begin errors++; $display("FAIL raw_dep_fire got %b exp 1", issue_fire); end
        checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL raw_stall_final got %0d exp 2", stall_cnt); end
`else
        checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL raw_wb_ready got %b exp 0", dec_ready); end
        tick();
        wb_valid = 0;
        #1;
        checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL raw_after_wb_ready got %b exp 1", dec_ready); end
        tick();
        dec_valid = 0;
        checks++; if (issue_fire !== 1'b1) begin errors++; $display("FAIL raw_dep_fire got %b exp 1", issue_fire); end
        checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL raw_stall_final got %0d exp 3", stall_cnt); end
`endif
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL raw_busy_clear got %h exp 0", busy_vec); end
        checks++; if (inflight_cnt !== 3'd0) begin errors++; $display("FAIL raw_cnt_clear got %0d exp 0", inflight_cnt); end
    endtask

    task automatic test_full();
        clear_inputs();
        for (int i = 2; i <= 5; i++) begin
            dec_valid = 1; dec_reg_write = 1; dec_rd = 5'(i);
            #1;
            checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL full_fill_ready%0d got %b exp 1", i, dec_ready); end
            tick();
        end
        checks++; if (inflight_cnt !== 3'd4) begin errors++; $display("FAIL full_cnt got %0d exp 4", inflight_cnt); end
        checks++; if (busy_vec !== 32'h3C) begin errors++; $display("FAIL full_busy got %h exp %h", busy_vec, 32'h3C); end
        dec_rd = 5'd6;
        #1;
        checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", dec_ready); end
        tick();
        wb_valid = 1; wb_rd = 5'd3;
        #1;
`ifdef SB_WB_BYPASS_EN
        checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL full_wb_ready got %b exp 1", dec_ready); end
        tick();
        wb_valid = 0; dec_valid = 0;
`else
        checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL full_wb_ready got %b exp 0", dec_ready); end
        tick();
        wb_valid = 0;
        checks++; if (inflight_cnt !== 3'd3) begin errors++; $display("FAIL full_cnt_mid got %0d exp 3", inflight_cnt); end
        #1;
        checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL full_free_ready got %b exp 1", dec_ready); end
        tick();
        dec_valid = 0;
`endif
        checks++; if (issue_fire !== 1'b1) begin errors++; $display("FAIL full_x6_fire got %b exp 1", issue_fire); end
        checks++; if (inflight_cnt !== 3'd4) begin errors++; $display("FAIL full_cnt_end got %0d exp 4", inflight_cnt); end
        checks++; if (busy_vec !== 32'h74) begin errors++; $display("FAIL full_busy_end got %h exp %h", busy_vec, 32'h74); end
    endtask

    task automatic test_xzr();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            dec_valid = 1; dec_reg_write = 1; dec_rd = 5'd31;
            dec_use_rn = 1; dec_rn = 5'd31; dec_use_r2 = 1; dec_r2 = 5'd31;
            wb_valid = (i == 3); wb_rd = 5'd31;
            #1;
            checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL xzr_ready%0d got %b exp 1", i, dec_ready); end
            tick();
            checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL xzr_busy%0d got %h exp 0", i, busy_vec); end
            checks++; if (inflight_cnt !== 3'd0) begin errors++; $display("FAIL xzr_cnt%0d got %0d exp 0", i, inflight_cnt); end
        end
        checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL xzr_wberr got %b exp 0", wb_err); end
        clear_inputs();
    endtask

    task automatic test_same_cycle();
        do_reset();
        dec_valid = 1; dec_reg_write = 1; dec_rd = 5'd2;
        tick();
        dec_rd = 5'd7; wb_valid = 1; wb_rd = 5'd2;
        #1;
        checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL same_ready got %b exp 1", dec_ready); end
        tick();
        clear_inputs();
        checks++; if (busy_vec !== 32'h80) begin errors++; $display("FAIL same_busy got %h exp %h", busy_vec, 32'h80); end
        checks++; if (inflight_cnt !== 3'd1) begin errors++; $display("FAIL same_cnt got %0d exp 1", inflight_cnt); end
        checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL same_wberr0 got %b exp 0", wb_err); end
        wb_valid = 1; wb_rd = 5'd9;
        tick();
        wb_valid = 0;
        checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL wberr_set got %b exp 1", wb_err); end
        tick(); tick();
        checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL wberr_hold got %b exp 1", wb_err); end
        checks++; if (busy_vec !== 32'h80) begin errors++; $display("FAIL wberr_busy got %h exp %h", busy_vec, 32'h80); end
        // Reset drops X7 tracking; its late writeback is an error.
        do_reset();
        wb_valid = 1; wb_rd = 5'd7;
        tick();
        wb_valid = 0;
        checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL late_wb_err got %b exp 1", wb_err); end
        checks++; if (inflight_cnt !== 3'd0) begin errors++; $display("FAIL late_wb_cnt got %0d exp 0", inflight_cnt); end
    endtask

    task automatic test_saturate();
        do_reset();
        dec_valid = 1; dec_reg_write = 1; dec_rd = 5'd1;
        tick();
        dec_reg_write = 0; dec_rd = 0; dec_use_rn = 1; dec_rn = 5'd1;
        for (int i = 0; i < 65534; i++) tick();
        checks++; if (stall_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got %h exp FFFE", stall_cnt); end
        tick();
        checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hit got %h exp FFFF", stall_cnt); end
        for (int i = 0; i < 4465; i++) tick();
        checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h exp FFFF", stall_cnt); end
        checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL sat_ready got %b exp 0", dec_ready); end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        test_reset();
        test_raw();
        test_full();
        test_xzr();
        test_same_cycle();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
